// File: rtl/fuzz_pkg.sv
// rtl/fuzz_pkg.sv - shared address map, fuzz FSM state encoding and helpers
package fuzz_pkg;

    localparam logic [31:0] TRAFFIC_START           = 32'h3000_0000;
    localparam logic [31:0] TRAFFIC_END             = 32'h3000_003C;
    localparam logic [31:0] TRIGGER_BASE            = 32'h3001_0000;
    localparam logic [31:0] TRIGGER_ACK_ADDR        = 32'h3001_0100;
    localparam logic [31:0] TRIGGER_ACK_DATA        = 32'h600D_ACC1;
    localparam logic [31:0] FUZZ_ACK_ADDR           = 32'h3002_0000;
    localparam logic [31:0] ANOMALY_INDICATION_ADDR = 32'h3002_0004;
    localparam logic [31:0] ANOMALY_INDICATION_DATA = 32'hDEAD_BEEF;
    localparam logic [31:0] ANOMALY_DATA_ADDR       = 32'h3002_0008;

    localparam int BUFFER_DEPTH = int'((TRAFFIC_END - TRAFFIC_START) / 4) + 1;
    localparam int IDX_W        = $clog2(BUFFER_DEPTH);

    // Encoding is visible to software through slave reads, so keep it fixed.
    typedef enum logic [2:0] {
        IDLE          = 3'd0,
        TRIG_WRITE    = 3'd1,
        TRIG_ACK_READ = 3'd2,
        MONITOR_READ  = 3'd3,
        WAIT_SAT      = 3'd4,
        TRANSMIT      = 3'd5,
        ANOMALY_WAIT  = 3'd6
    } fuzz_state_t;

    // Byte address of buffer word idx inside the traffic window.
    function automatic logic [31:0] traffic_addr(input logic [IDX_W-1:0] idx);
        return TRAFFIC_START + 32'({idx, 2'b00});
    endfunction

endpackage

// File: rtl/fuzz_fsm.sv
// rtl/fuzz_fsm.sv - fuzz session sequencer driving the Wishbone master port
module fuzz_fsm
    import fuzz_pkg::*;
#(
    parameter int ADDR_WIDTH        = 32,
    parameter int DATA_WIDTH        = 32,
    parameter int IP_NUM            = 4,
    parameter int IP_SELECTOR_WIDTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    // session control
    input  logic [1:0]                   mode_selector,
    input  logic [IP_SELECTOR_WIDTH-1:0] ip_selector,
    // flags latched by the slave side, and their consume strobes
    input  logic                         fuzz_ack,
    input  logic                         anomaly,
    input  logic                         anomaly_data_wr,
    output logic                         fuzz_ack_clr,
    output logic                         anomaly_clr,
    output logic [2:0]                   state,
    // capture buffer access
    output logic                         buf_wr_en,
    output logic [IDX_W-1:0]             buf_wr_idx,
    output logic [IDX_W-1:0]             buf_rd_idx,
    input  logic [DATA_WIDTH-1:0]        buf_rd_data,
    // Wishbone master
    output logic                         wbm_cyc_o,
    output logic                         wbm_stb_o,
    output logic                         wbm_we_o,
    output logic [ADDR_WIDTH-1:0]        wbm_adr_o,
    output logic [DATA_WIDTH-1:0]        wbm_dat_o,
    output logic [DATA_WIDTH/8-1:0]      wbm_sel_o,
    output logic [2:0]                   wbm_cti_o,
    output logic [1:0]                   wbm_bte_o,
    input  logic [DATA_WIDTH-1:0]        wbm_dat_i,
    input  logic                         wbm_ack_i
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BUFFER_DEPTH - 1);

    fuzz_state_t                  state_r, state_n;
    logic [IDX_W-1:0]             idx_r, idx_n;
    logic                         session_done_r, session_done_n;
    logic                         stb_r, stb_n;
    logic                         we_r, we_n;
    logic [ADDR_WIDTH-1:0]        adr_r, adr_n;
    logic [DATA_WIDTH-1:0]        dat_r, dat_n;
    logic                         xfer_done;
    logic [IP_SELECTOR_WIDTH-1:0] ip_eff;
    logic [ADDR_WIDTH-1:0]        trig_adr;

    assign ip_eff   = (int'(ip_selector) < IP_NUM) ? ip_selector : '0;
    assign trig_adr = ADDR_WIDTH'(TRIGGER_BASE + 32'({ip_eff, 2'b00}));

    // A transfer completes on any posedge where our strobe meets an ack.
    assign xfer_done = stb_r & wbm_ack_i;

    // The word sent next in TRANSMIT is fetched one index ahead so it can be
    // loaded onto wbm_dat_o in the same cycle the previous write is acked.
    assign buf_rd_idx = (state_r == TRANSMIT) ? idx_r + IDX_W'(1) : '0;
    assign buf_wr_idx = idx_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= IDLE;
            idx_r          <= '0;
            session_done_r <= 1'b0;
            stb_r          <= 1'b0;
            we_r           <= 1'b0;
            adr_r          <= '0;
            dat_r          <= '0;
        end else begin
            state_r        <= state_n;
            idx_r          <= idx_n;
            session_done_r <= session_done_n;
            stb_r          <= stb_n;
            we_r           <= we_n;
            adr_r          <= adr_n;
            dat_r          <= dat_n;
        end
    end

    always_comb begin
        state_n        = state_r;
        idx_n          = idx_r;
        session_done_n = session_done_r;
        stb_n          = stb_r;
        we_n           = we_r;
        adr_n          = adr_r;
        dat_n          = dat_r;
        fuzz_ack_clr   = 1'b0;
        anomaly_clr    = 1'b0;
        buf_wr_en      = 1'b0;

        case (state_r)
            IDLE: begin
                if (mode_selector != 2'b00 && !session_done_r) begin
                    state_n = TRIG_WRITE;
                    stb_n   = 1'b1;
                    we_n    = 1'b1;
                    adr_n   = trig_adr;
                    dat_n   = DATA_WIDTH'(mode_selector);
                end
            end
            TRIG_WRITE: begin
                if (xfer_done) begin
                    state_n = TRIG_ACK_READ;
                    we_n    = 1'b0;
                    adr_n   = ADDR_WIDTH'(TRIGGER_ACK_ADDR);
                end
            end
            TRIG_ACK_READ: begin
                // Wrong data leaves stb high on the same address: a re-read.
                if (xfer_done && wbm_dat_i == DATA_WIDTH'(TRIGGER_ACK_DATA)) begin
                    state_n = MONITOR_READ;
                    idx_n   = '0;
                    adr_n   = ADDR_WIDTH'(traffic_addr('0));
                end
            end
            MONITOR_READ: begin
                if (xfer_done) begin
                    buf_wr_en = 1'b1;
                    if (idx_r == LAST_IDX) begin
                        state_n = WAIT_SAT;
                        stb_n   = 1'b0;
                    end else begin
                        idx_n = idx_r + IDX_W'(1);
                        adr_n = ADDR_WIDTH'(traffic_addr(idx_r + IDX_W'(1)));
                    end
                end
            end
            WAIT_SAT: begin
                if (anomaly) begin
                    state_n     = ANOMALY_WAIT;
                    anomaly_clr = 1'b1;
                end else if (fuzz_ack) begin
                    state_n      = TRANSMIT;
                    fuzz_ack_clr = 1'b1;
                    idx_n        = '0;
                    stb_n        = 1'b1;
                    we_n         = 1'b1;
                    adr_n        = ADDR_WIDTH'(traffic_addr('0));
                    dat_n        = buf_rd_data;
                end
            end
            TRANSMIT: begin
                if (xfer_done) begin
                    if (idx_r == LAST_IDX) begin
                        state_n = IDLE;
                        stb_n   = 1'b0;
                        we_n    = 1'b0;
                    end else begin
                        idx_n = idx_r + IDX_W'(1);
                        adr_n = ADDR_WIDTH'(traffic_addr(idx_r + IDX_W'(1)));
                        dat_n = buf_rd_data;
                    end
                end
            end
            ANOMALY_WAIT: begin
                if (anomaly_data_wr) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                stb_n   = 1'b0;
                we_n    = 1'b0;
            end
        endcase

        // One session per mode selection: re-arming needs mode 00 first.
        if (state_n == IDLE && state_r != IDLE) begin
            session_done_n = 1'b1;
        end
        if (mode_selector == 2'b00) begin
            session_done_n = 1'b0;
        end
    end

    assign state     = state_r;
    assign wbm_cyc_o = stb_r;
    assign wbm_stb_o = stb_r;
    assign wbm_we_o  = we_r;
    assign wbm_adr_o = adr_r;
    assign wbm_dat_o = dat_r;
    assign wbm_sel_o = '1;
    assign wbm_cti_o = 3'b000;
    assign wbm_bte_o = 2'b00;

endmodule

// File: rtl/central_top.sv
// rtl/central_top.sv - fuzz controller top: slave decode, flags, capture buffer
module central_top
    import fuzz_pkg::*;
#(
    parameter int ADDR_WIDTH        = 32,
    parameter int DATA_WIDTH        = 32,
    parameter int EXT_RW_WIDTH      = 32,
    parameter int IP_NUM            = 4,
    parameter int IP_SELECTOR_WIDTH = 2,
    parameter int TRAFFIC_N         = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    // session control and anomaly result
    input  logic [1:0]                   mode_selector,
    input  logic [IP_SELECTOR_WIDTH-1:0] ip_selector,
    output logic [EXT_RW_WIDTH-1:0]      corner_case_payload,
    // Wishbone slave
    input  logic                         wbs_cyc_i,
    input  logic                         wbs_stb_i,
    input  logic                         wbs_we_i,
    input  logic [ADDR_WIDTH-1:0]        wbs_adr_i,
    input  logic [DATA_WIDTH-1:0]        wbs_dat_i,
    input  logic [DATA_WIDTH/8-1:0]      wbs_sel_i,
    input  logic [2:0]                   wbs_cti_i,
    input  logic [1:0]                   wbs_bte_i,
    output logic [DATA_WIDTH-1:0]        wbs_dat_o,
    output logic                         wbs_ack_o,
    // Wishbone master
    output logic                         wbm_cyc_o,
    output logic                         wbm_stb_o,
    output logic                         wbm_we_o,
    output logic [ADDR_WIDTH-1:0]        wbm_adr_o,
    output logic [DATA_WIDTH-1:0]        wbm_dat_o,
    output logic [DATA_WIDTH/8-1:0]      wbm_sel_o,
    output logic [2:0]                   wbm_cti_o,
    output logic [1:0]                   wbm_bte_o,
    input  logic [DATA_WIDTH-1:0]        wbm_dat_i,
    input  logic                         wbm_ack_i
);

    logic [DATA_WIDTH-1:0] buffer [BUFFER_DEPTH];

    logic                  wbs_req;
    logic                  wbs_wr;
    logic                  fuzz_ack_r;
    logic                  anomaly_r;
    logic                  fuzz_ack_set;
    logic                  anomaly_set;
    logic                  anomaly_data_wr;
    logic                  fuzz_ack_clr;
    logic                  anomaly_clr;
    logic [2:0]            fsm_state;
    logic                  buf_wr_en;
    logic [IDX_W-1:0]      buf_wr_idx;
    logic [IDX_W-1:0]      buf_rd_idx;
    logic [DATA_WIDTH-1:0] buf_rd_data;
    logic                  unused_ok;

    assign unused_ok = ^{wbs_sel_i, wbs_cti_i, wbs_bte_i, (TRAFFIC_N != 2)};

    assign wbs_req = wbs_cyc_i & wbs_stb_i;
    // Writes take effect only on the single cycle ack is high.
    assign wbs_wr  = wbs_ack_o & wbs_req & wbs_we_i;

    assign fuzz_ack_set    = wbs_wr && wbs_adr_i == ADDR_WIDTH'(FUZZ_ACK_ADDR);
    assign anomaly_set     = wbs_wr && wbs_adr_i == ADDR_WIDTH'(ANOMALY_INDICATION_ADDR)
                             && wbs_dat_i == DATA_WIDTH'(ANOMALY_INDICATION_DATA);
    assign anomaly_data_wr = wbs_wr && wbs_adr_i == ADDR_WIDTH'(ANOMALY_DATA_ADDR);

    always_ff @(posedge clk) begin
        if (rst) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= wbs_req & ~wbs_ack_o;
            if (wbs_req & ~wbs_ack_o) begin
                wbs_dat_o <= {{(DATA_WIDTH-3){1'b0}}, fsm_state};
            end
        end
    end

    // A fresh write wins over a same-cycle consume so no request is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            fuzz_ack_r <= 1'b0;
            anomaly_r  <= 1'b0;
        end else begin
            fuzz_ack_r <= fuzz_ack_set | (fuzz_ack_r & ~fuzz_ack_clr);
            anomaly_r  <= anomaly_set  | (anomaly_r  & ~anomaly_clr);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            corner_case_payload <= '0;
        end else if (anomaly_data_wr && fsm_state == ANOMALY_WAIT) begin
            corner_case_payload <= wbs_dat_i[EXT_RW_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (buf_wr_en) begin
            buffer[buf_wr_idx] <= wbm_dat_i;
        end
    end

    assign buf_rd_data = buffer[buf_rd_idx];

    fuzz_fsm #(
        .ADDR_WIDTH        (ADDR_WIDTH),
        .DATA_WIDTH        (DATA_WIDTH),
        .IP_NUM            (IP_NUM),
        .IP_SELECTOR_WIDTH (IP_SELECTOR_WIDTH)
    ) fuzz_fsm (
        .clk             (clk),
        .rst             (rst),
        .mode_selector   (mode_selector),
        .ip_selector     (ip_selector),
        .fuzz_ack        (fuzz_ack_r),
        .anomaly         (anomaly_r),
        .anomaly_data_wr (anomaly_data_wr),
        .fuzz_ack_clr    (fuzz_ack_clr),
        .anomaly_clr     (anomaly_clr),
        .state           (fsm_state),
        .buf_wr_en       (buf_wr_en),
        .buf_wr_idx      (buf_wr_idx),
        .buf_rd_idx      (buf_rd_idx),
        .buf_rd_data     (buf_rd_data),
        .wbm_cyc_o       (wbm_cyc_o),
        .wbm_stb_o       (wbm_stb_o),
        .wbm_we_o        (wbm_we_o),
        .wbm_adr_o       (wbm_adr_o),
        .wbm_dat_o       (wbm_dat_o),
        .wbm_sel_o       (wbm_sel_o),
        .wbm_cti_o       (wbm_cti_o),
        .wbm_bte_o       (wbm_bte_o),
        .wbm_dat_i       (wbm_dat_i),
        .wbm_ack_i       (wbm_ack_i)
    );

endmodule

// File: tb/tb_central_top.sv
// tb/tb_central_top.sv - randomized self-checking bench for central_top
module tb_central_top;

    localparam logic [31:0] START     = 32'h3000_0000;
    localparam logic [31:0] TRIG      = 32'h3001_0000;
    localparam logic [31:0] ACK_ADDR  = 32'h3001_0100;
    localparam logic [31:0] ACK_DATA  = 32'h600D_ACC1;
    localparam logic [31:0] FACK_ADDR = 32'h3002_0000;
    localparam logic [31:0] IND_ADDR  = 32'h3002_0004;
    localparam logic [31:0] IND_DATA  = 32'hDEAD_BEEF;
    localparam logic [31:0] ANOM_ADDR = 32'h3002_0008;
    localparam int          ST_IDLE   = 0;
    localparam int          ST_WAIT   = 4;
    localparam int          ST_ANOM   = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode_selector;
    logic [1:0]  ip_selector;
    logic [31:0] corner_case_payload;
    logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [31:0] wbs_adr_i, wbs_dat_i, wbs_dat_o;
    logic [3:0]  wbs_sel_i;
    logic [2:0]  wbs_cti_i;
    logic [1:0]  wbs_bte_i;
    logic        wbs_ack_o;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic [3:0]  wbm_sel_o;
    logic [2:0]  wbm_cti_o;
    logic [1:0]  wbm_bte_o;
    logic        wbm_ack_i;

    always #5 clk = ~clk;

    central_top dut (
        .clk(clk), .rst(rst), .mode_selector(mode_selector), .ip_selector(ip_selector),
        .corner_case_payload(corner_case_payload),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_sel_i(wbs_sel_i),
        .wbs_cti_i(wbs_cti_i), .wbs_bte_i(wbs_bte_i), .wbs_dat_o(wbs_dat_o),
        .wbs_ack_o(wbs_ack_o),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
        .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o), .wbm_dat_i(wbm_dat_i),
        .wbm_ack_i(wbm_ack_i)
    );

    int total = 0;
    int bad   = 0;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference model: expected master transfers, satellite memory, flags.
    typedef struct {
        bit          we;
        logic [31:0] adr;
        logic [31:0] dat;
    } xfer_t;

    xfer_t       exp_q[$];
    int          n_seen    = 0;
    int          n_pushed  = 0;
    logic [31:0] mem [16];
    int          bad_left  = 0;
    bit          resp_en   = 1'b1;
    bit          fuzz_flag = 1'b0;
    bit          anom_flag = 1'b0;
    logic [31:0] payload_exp = '0;

    function automatic void push_x(input bit we, input logic [31:0] a, input logic [31:0] d);
        xfer_t e;
        e.we = we;
        e.adr = a;
        e.dat = d;
        exp_q.push_back(e);
        n_pushed++;
    endfunction

    function automatic logic [31:0] read_resp(input logic [31:0] a);
        logic [31:0] r;
        if (a == ACK_ADDR) begin
            if (bad_left > 0) begin
                bad_left--;
                r = $urandom;
                if (r == ACK_DATA) r = r ^ 32'h1;
            end else begin
                r = ACK_DATA;
            end
        end else if (a >= START && a < START + 32'd64) begin
            r = mem[int'((a - START) >> 2)];
        end else begin
            r = $urandom;
        end
        return r;
    endfunction

    // Satellite side of the master bus with 0..2 cycles of ack latency.
    initial begin
        int    lat;
        xfer_t e;
        lat       = 0;
        wbm_ack_i = 1'b0;
        wbm_dat_i = '0;
        forever begin
            @(negedge clk);
            wbm_ack_i = 1'b0;
            if (resp_en && wbm_cyc_o && wbm_stb_o) begin
                if (lat > 0) begin
                    lat--;
                end else begin
                    n_seen++;
                    if (exp_q.size() == 0) begin
                        expect_eq("xfer_unexpected", n_seen, n_pushed);
                    end else begin
                        e = exp_q.pop_front();
                        expect_eq("xfer_we", wbm_we_o, e.we);
                        expect_eq("xfer_adr", wbm_adr_o, e.adr);
                        if (e.we) expect_eq("xfer_dat", wbm_dat_o, e.dat);
                    end
                    wbm_dat_i = read_resp(wbm_adr_o);
                    wbm_ack_i = 1'b1;
                    lat = $urandom_range(0, 2);
                end
            end
        end
    end

    task automatic wbs_xfer(input bit we, input logic [31:0] a, input logic [31:0] d,
                            output logic [31:0] rd);
        int acks = 0;
        int n    = 0;
        @(negedge clk);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = we;
        wbs_adr_i = a;
        wbs_dat_i = d;
        do begin
            @(negedge clk);
            n++;
        end while (!wbs_ack_o && n < 20);
        if (wbs_ack_o) begin
            acks = 1;
            rd   = wbs_dat_o;
        end else begin
            rd = 'x;
        end
        @(negedge clk);
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        if (wbs_ack_o) acks++;
        @(negedge clk);
        if (wbs_ack_o) acks++;
        expect_eq("wbs_ack_pulses", acks, 1);
    endtask

    task automatic slave_write(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] rd;
        wbs_xfer(1'b1, a, d, rd);
    endtask

    task automatic check_state(input string tag, input int exp);
        logic [31:0] rd;
        wbs_xfer(1'b0, 32'h3000_1000, '0, rd);
        expect_eq(tag, rd, exp);
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        expect_eq({tag, "_drained"}, exp_q.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    function automatic void push_transmit();
        for (int i = 0; i < 16; i++) push_x(1'b1, START + 4 * i, mem[i]);
    endfunction

    task automatic run_session(input logic [1:0] m, input int ip, input int nbad, input bit beef);
        int outcome;
        @(negedge clk);
        mode_selector = 2'b00;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 16; i++) mem[i] = beef ? 32'hBEEF_0000 + i : $urandom;
        bad_left = nbad;
        push_x(1'b1, TRIG + 4 * ip, {30'b0, m});
        for (int i = 0; i <= nbad; i++) push_x(1'b0, ACK_ADDR, '0);
        for (int i = 0; i < 16; i++) push_x(1'b0, START + 4 * i, '0);
        if (anom_flag) begin
            anom_flag = 1'b0;
            outcome   = ST_ANOM;
        end else if (fuzz_flag) begin
            fuzz_flag = 1'b0;
            push_transmit();
            outcome = ST_IDLE;
        end else begin
            outcome = ST_WAIT;
        end
        ip_selector   = 2'(ip);
        mode_selector = m;
        wait_drain("session");
        check_state("state_after_monitor", outcome);
    endtask

    task automatic finish_fuzz_ack();
        push_transmit();
        slave_write(FACK_ADDR, $urandom);
        wait_drain("transmit");
        check_state("state_after_transmit", ST_IDLE);
        repeat (30) @(negedge clk);
        expect_eq("no_retrigger", n_seen, n_pushed);
    endtask

    task automatic finish_anomaly(input logic [31:0] pl);
        logic [31:0] wrong;
        wrong = $urandom;
        if (wrong == IND_DATA) wrong = wrong ^ 32'h8;
        slave_write(IND_ADDR, wrong);
        check_state("state_bad_indication", ST_WAIT);
        slave_write(IND_ADDR, IND_DATA);
        check_state("state_anomaly_wait", ST_ANOM);
        slave_write(ANOM_ADDR, pl);
        payload_exp = pl;
        check_state("state_after_payload", ST_IDLE);
        expect_eq("payload", corner_case_payload, payload_exp);
    endtask

    initial begin
        logic [31:0] pl;
        int          cnt;
        rst = 1'b1;
        mode_selector = 2'b00;
        ip_selector = 2'b00;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        wbs_adr_i = '0; wbs_dat_i = '0; wbs_sel_i = 4'hF; wbs_cti_i = 3'b000; wbs_bte_i = 2'b00;
        repeat (4) @(negedge clk);
        expect_eq("rst_wbs_ack", wbs_ack_o, 0);
        expect_eq("rst_wbs_dat", wbs_dat_o, 0);
        expect_eq("rst_wbm_cyc", wbm_cyc_o, 0);
        expect_eq("rst_wbm_stb", wbm_stb_o, 0);
        expect_eq("rst_wbm_we", wbm_we_o, 0);
        expect_eq("rst_wbm_adr", wbm_adr_o, 0);
        expect_eq("rst_wbm_dat", wbm_dat_o, 0);
        expect_eq("rst_payload", corner_case_payload, 0);
        rst = 1'b0;
        check_state("state_reset", ST_IDLE);

        // Basic session: trigger IP 1, monitor, fuzz ack, transmit.
        run_session(2'b01, 1, 0, 1'b1);
        finish_fuzz_ack();
        expect_eq("sel_all_ones", wbm_sel_o, 4'hF);

        // Wrong trigger acks force re-reads; then the anomaly path.
        run_session(2'b01, 2, 3, 1'b0);
        finish_anomaly(32'hC0FFEE01);

        // Payload write outside ANOMALY_WAIT is ignored; flags latch while idle.
        slave_write(ANOM_ADDR, 32'h1234_5678);
        expect_eq("payload_ignored", corner_case_payload, payload_exp);
        slave_write(FACK_ADDR, 32'h0);
        slave_write(IND_ADDR, IND_DATA);
        fuzz_flag = 1'b1;
        anom_flag = 1'b1;

        // Anomaly beats the pending fuzz ack; the fuzz ack then serves the next session.
        run_session(2'($urandom_range(1, 3)), $urandom_range(0, 3), $urandom_range(0, 2), 1'b0);
        pl = $urandom;
        slave_write(ANOM_ADDR, pl);
        payload_exp = pl;
        check_state("state_after_priority", ST_IDLE);
        expect_eq("payload_priority", corner_case_payload, payload_exp);
        run_session(2'($urandom_range(1, 3)), $urandom_range(0, 3), $urandom_range(0, 2), 1'b0);

        for (int s = 0; s < 4; s++) begin
            run_session(2'($urandom_range(1, 3)), $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
            if ($urandom_range(0, 1) == 0) finish_fuzz_ack();
            else finish_anomaly($urandom);
        end

        // Reset in the middle of a monitor burst.
        @(negedge clk);
        mode_selector = 2'b00;
        repeat (2) @(negedge clk);
        bad_left = 0;
        push_x(1'b1, TRIG, 32'h1);
        push_x(1'b0, ACK_ADDR, '0);
        for (int i = 0; i < 16; i++) push_x(1'b0, START + 4 * i, '0);
        cnt = n_seen;
        ip_selector = 2'b00;
        mode_selector = 2'b01;
        for (int n = 0; n < 200 && n_seen < cnt + 6; n++) @(negedge clk);
        @(posedge clk);
        #1;
        expect_eq("busy_before_reset", wbm_stb_o, 1);
        resp_en = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        expect_eq("abort_stb", wbm_stb_o, 0);
        expect_eq("abort_cyc", wbm_cyc_o, 0);
        expect_eq("abort_payload", corner_case_payload, 0);
        mode_selector = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        n_pushed = n_seen;
        resp_en = 1'b1;
        check_state("state_after_abort", ST_IDLE);
        repeat (10) @(negedge clk);
        expect_eq("idle_after_abort", wbm_stb_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/central_top.md
CENTRAL_TOP -- requirements
Module: central_top

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, 32, bus address width; DATA_WIDTH, 32, bus data width; EXT_RW_WIDTH, 32, corner_case_payload width; IP_NUM, 4, satellite IPs; IP_SELECTOR_WIDTH, 2, ip_selector width; TRAFFIC_N, 2, entries in traffic address map (start, end).
REQ-002 clk  in  1  sole clock; one clock domain, all logic on posedge clk.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 mode_selector  in  2  fuzz mode (00 none, 01 mutated, 10/11 reserved-as-01); ip_selector  in  IP_SELECTOR_WIDTH  target satellite IP.
REQ-005 corner_case_payload  out  EXT_RW_WIDTH  last anomaly payload captured.
REQ-006 Wishbone slave: wbs_cyc_i, wbs_stb_i, wbs_we_i in 1; wbs_adr_i in ADDR_WIDTH; wbs_dat_i in DATA_WIDTH; wbs_sel_i in DATA_WIDTH/8; wbs_cti_i in 3; wbs_bte_i in 2; wbs_dat_o out DATA_WIDTH; wbs_ack_o out 1.
REQ-007 Wishbone master: wbm_cyc_o, wbm_stb_o, wbm_we_o out 1; wbm_adr_o out ADDR_WIDTH; wbm_dat_o out DATA_WIDTH; wbm_sel_o out DATA_WIDTH/8; wbm_cti_o out 3; wbm_bte_o out 2; wbm_dat_i in DATA_WIDTH; wbm_ack_i in 1.

Function
REQ-008 Address map constants: TRAFFIC start 0x3000_0000, end 0x3000_003C (BUFFER_DEPTH=(end-start)/4+1=16); TRIGGER_BASE 0x3001_0000 (IP n at +4n); TRIGGER_ACK_ADDR 0x3001_0100, TRIGGER_ACK_DATA 0x600D_ACC1; FUZZ_ACK_ADDR 0x3002_0000; ANOMALY_INDICATION_ADDR 0x3002_0004, ANOMALY_INDICATION_DATA 0xDEAD_BEEF; ANOMALY_DATA_ADDR 0x3002_0008.
REQ-009 Slave: wbs_ack_o registered, ack <= cyc&stb&~ack, giving exactly one ack pulse per request; write side effects occur only in the ack cycle.
REQ-010 Slave reads return {29'b0, state_r} on wbs_dat_o; writes to unmapped addresses are acked and ignored.
REQ-011 Master: one transfer at a time; stb/cyc held with address/data stable until a posedge with wbm_ack_i=1 (combinational same-cycle ack supported); stb/cyc drop the following cycle unless the next transfer starts; wbm_sel_o all ones; wbm_cti_o=000; wbm_bte_o=00.
REQ-012 FSM (fuzz_fsm, register state_r) states: IDLE, TRIG_WRITE, TRIG_ACK_READ, MONITOR_READ, WAIT_SAT, TRANSMIT, ANOMALY_WAIT.
REQ-013 IDLE -> TRIG_WRITE when mode_selector!=00 and session_done=0; session_done sets on every return to IDLE and clears when mode_selector==00.
REQ-014 TRIG_WRITE: master write {30'b0, mode_selector} to TRIGGER_BASE+4*ip_selector (ip_selector>=IP_NUM targets IP 0); on ack -> TRIG_ACK_READ.
REQ-015 TRIG_ACK_READ: master read TRIGGER_ACK_ADDR; data==TRIGGER_ACK_DATA -> MONITOR_READ, else re-read.
REQ-016 MONITOR_READ: master reads start..end in steps of 4, storing word i into buffer[i]; after index BUFFER_DEPTH-1 acked -> WAIT_SAT.
REQ-017 Slave writes SHALL be latched as flags in any state: FUZZ_ACK_ADDR (any data) sets fuzz_ack_r; ANOMALY_INDICATION_ADDR with data ANOMALY_INDICATION_DATA sets anomaly_r (other data ignored).
REQ-018 WAIT_SAT: anomaly_r -> ANOMALY_WAIT (priority over fuzz_ack_r); else fuzz_ack_r -> TRANSMIT; flags clear on consumption.
REQ-019 TRANSMIT: master writes buffer[i] to start+4i for i=0..BUFFER_DEPTH-1; after last ack -> IDLE.
REQ-020 ANOMALY_WAIT: slave write to ANOMALY_DATA_ADDR loads wbs_dat_i[EXT_RW_WIDTH-1:0] into corner_case_payload and -> IDLE in the same ack cycle.
REQ-021 Buffer index wraps never: counter width clog2(BUFFER_DEPTH), terminal at BUFFER_DEPTH-1.

Reset
REQ-022 rst SHALL set state_r=IDLE, all wbm_* strobes/we=0, wbm_adr_o/wbm_dat_o=0, wbs_ack_o=0, wbs_dat_o=0, flags=0, session_done=0, corner_case_payload=0, index=0; buffer contents not reset.
REQ-023 rst mid-transfer SHALL abort immediately (stb/cyc low next cycle).

Structure
REQ-024 Address/data constants and the state enum SHALL reside in shared package fuzz_pkg.
REQ-025 FSM plus master port SHALL be sub-module fuzz_fsm instantiated as instance fuzz_fsm; slave decode and buffer in central_top.

Verification
REQ-026 Reset then mode=01, ip=01 -> master write 0x1 to 0x3001_0004, read 0x3001_0100 returning 0x600D_ACC1 -> MONITOR_READ.
REQ-027 Monitor: memory returns 0xBEEF0000+i -> 16 reads 0x3000_0000..0x3000_003C, then WAIT_SAT.
REQ-028 Slave write 0x3002_0000 -> 16 master writes of 0xBEEF0000+i to same addresses, then IDLE; no retrigger while mode stays 01.
REQ-029 Slave write 0xDEAD_BEEF to 0x3002_0004 then 0xC0FFEE01 to 0x3002_0008 -> IDLE, corner_case_payload=0xC0FFEE01.
REQ-030 Trigger ack read returning wrong data -> repeated reads until 0x600D_ACC1; each slave write sees exactly one wbs_ack_o pulse.
